mux4_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one 4:1 2-bit mux (mux4_1) among four requesters.

---
 rtl/mux4_rr_sched_pkg.sv | 28 ++
 rtl/mux4_rr_sched_mux4_1.sv | 23 ++
 rtl/mux4_rr_sched.sv | 99 +++++++++
 tb/tb_mux4_rr_sched.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_sched_pkg.sv
// Shared types and helpers for the four-requester round-robin mux scheduler.
package mux4_rr_sched_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index of the first set bit of req, searching from last+1 upward modulo NUM_REQ.
  // The loop runs from lowest to highest priority, so the last hit is the winner.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0] idx;
    rr_pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_sched_mux4_1.sv
// Plain 4:1 mux of 2-bit words; {sel2,sel1}=i selects in(i+1).
module mux4_1 (
  input  logic [1:0] in1,
  input  logic [1:0] in2,
  input  logic [1:0] in3,
  input  logic [1:0] in4,
  input  logic       sel1,
  input  logic       sel2,
  output logic [1:0] out
);

  always_comb begin
    out = in1;
    case ({sel2, sel1})
      2'd0: out = in1;
      2'd1: out = in2;
      2'd2: out = in3;
      2'd3: out = in4;
      default: out = in1;
    endcase
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one mux4_1 among four requesters, with bursts of up to
// MAX_BURST beats per grant and a valid/ready output port.
module mux4_rr_sched
  import mux4_rr_sched_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         in1,
  input  logic [1:0]         in2,
  input  logic [1:0]         in3,
  input  logic [1:0]         in4,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] ack,
  output logic               sel1,
  output logic               sel2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_data
);

  localparam logic [CNT_W:0] BURST_LIM = (CNT_W+1)'(MAX_BURST);

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] pick;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             accept;

  assign pick    = rr_pick(req, last);
  assign cnt_inc = {1'b0, cnt} + 1'b1;

  // gnt is zero outside GRANT, so masking with it also qualifies on state.
  assign out_valid = |(gnt & req);
  assign accept    = out_valid & out_ready;
  assign ack       = accept ? gnt : '0;

  assign sel1 = sel[0];
  assign sel2 = sel[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      last  <= SEL_W'(NUM_REQ-1);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            gnt   <= onehot(pick);
            sel   <= pick;
            last  <= pick;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (!out_valid) begin
            // Requester withdrew before its beat was taken; pointer already moved on.
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
          end else if (accept) begin
            if (cnt_inc < BURST_LIM) begin
              cnt <= cnt_inc[CNT_W-1:0];
            end else begin
              state <= IDLE;
              gnt   <= '0;
              cnt   <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  mux4_1 u_mux (
    .in1  (in1),
    .in2  (in2),
    .in3  (in3),
    .in4  (in4),
    .sel1 (sel1),
    .sel2 (sel2),
    .out  (out_data)
  );

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: default-burst instance plus a MAX_BURST=1 instance.
module tb_mux4_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [1:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic       out_ready = 1'b0;

  logic [3:0] gnt0, ack0, gnt1, ack1;
  logic       s1_0, s2_0, v0, s1_1, s2_1, v1;
  logic [1:0] d0, d1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux4_rr_sched #(.MAX_BURST(4), .CNT_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .gnt(gnt0), .ack(ack0), .sel1(s1_0), .sel2(s2_0), .out_valid(v0),
    .out_ready(out_ready), .out_data(d0)
  );

  mux4_rr_sched #(.MAX_BURST(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .gnt(gnt1), .ack(ack1), .sel1(s1_1), .sel2(s2_1), .out_valid(v1),
    .out_ready(out_ready), .out_data(d1)
  );

  // {gnt, ack, sel2, sel1, out_valid, out_data}
  wire [12:0] obs0 = {gnt0, ack0, s2_0, s1_0, v0, d0};
  wire [12:0] obs1 = {gnt1, ack1, s2_1, s1_1, v1, d1};

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    in1 = 2'b00; in2 = 2'b00; in3 = 2'b00; in4 = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    @(negedge clk);
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
    #1;
    exp = '0;
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL reset_hold got %b exp %b", obs0, exp); end
    @(negedge clk); #1;
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL reset_over_edge got %b exp %b", obs0, exp); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    exp = {4'b0001, 4'b0001, 2'b00, 1'b1, 2'b00};
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL reset_first_gnt got %b exp %b", obs0, exp); end
  endtask

  task automatic test_single_burst();
    logic [12:0] exp;
    do_reset();
    in3 = 2'b10; req = 4'b0100; out_ready = 1'b1;
    #1;
    exp = {4'b0000, 4'b0000, 2'b00, 1'b0, 2'b00};
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL single_idle got %b exp %b", obs0, exp); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); #1;
      exp = {4'b0100, 4'b0100, 2'b10, 1'b1, 2'b10};
      vectors++;
      if (obs0 !== exp) begin miscompares++; $display("FAIL single_beat%0d got %b exp %b", b, obs0, exp); end
    end
    @(negedge clk); #1;
    exp = {4'b0000, 4'b0000, 2'b10, 1'b0, 2'b10};
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL single_bubble got %b exp %b", obs0, exp); end
    @(negedge clk); #1;
    exp = {4'b0100, 4'b0100, 2'b10, 1'b1, 2'b10};
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL single_regrant got %b exp %b", obs0, exp); end
  endtask

  task automatic test_rr_burst1();
    logic [12:0] exp;
    logic [1:0]  kk;
    do_reset();
    in1 = 2'b00; in2 = 2'b01; in3 = 2'b10; in4 = 2'b11;
    req = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      kk = k[1:0];
      @(negedge clk); #1;
      exp = {4'b0001 << kk, 4'b0001 << kk, kk, 1'b1, kk};
      vectors++;
      if (obs1 !== exp) begin miscompares++; $display("FAIL rr_grant%0d got %b exp %b", k, obs1, exp); end
      @(negedge clk); #1;
      exp = {4'b0000, 4'b0000, kk, 1'b0, kk};
      vectors++;
      if (obs1 !== exp) begin miscompares++; $display("FAIL rr_bubble%0d got %b exp %b", k, obs1, exp); end
    end
  endtask

  task automatic test_stall();
    logic [12:0] exp;
    do_reset();
    in2 = 2'b01; req = 4'b0010; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      exp = {4'b0010, 4'b0000, 2'b01, 1'b1, 2'b01};
      vectors++;
      if (obs0 !== exp) begin miscompares++; $display("FAIL stall_cyc%0d got %b exp %b", c, obs0, exp); end
    end
    out_ready = 1'b1;
    #1;
    exp = {4'b0010, 4'b0010, 2'b01, 1'b1, 2'b01};
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL stall_release got %b exp %b", obs0, exp); end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    exp = {4'b0010, 4'b0000, 2'b01, 1'b1, 2'b01};
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL stall_single_ack got %b exp %b", obs0, exp); end
  endtask

  task automatic test_abort();
    logic [12:0] exp;
    do_reset();
    in3 = 2'b10; in4 = 2'b11; req = 4'b0100; out_ready = 1'b0;
    @(negedge clk); #1;
    exp = {4'b0100, 4'b0000, 2'b10, 1'b1, 2'b10};
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL abort_grant got %b exp %b", obs0, exp); end
    req = 4'b1000;
    #1;
    exp = {4'b0100, 4'b0000, 2'b10, 1'b0, 2'b10};
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL abort_drop got %b exp %b", obs0, exp); end
    @(negedge clk); #1;
    exp = {4'b0000, 4'b0000, 2'b10, 1'b0, 2'b10};
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL abort_idle got %b exp %b", obs0, exp); end
    @(negedge clk); #1;
    exp = {4'b1000, 4'b0000, 2'b11, 1'b1, 2'b11};
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL abort_next_req3 got %b exp %b", obs0, exp); end
  endtask

  task automatic test_async_reset();
    logic [12:0] exp;
    do_reset();
    req = 4'b0001; out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); #1;
      exp = {4'b0001, 4'b0001, 2'b00, 1'b1, 2'b00};
      vectors++;
      if (obs0 !== exp) begin miscompares++; $display("FAIL async_beat%0d got %b exp %b", b, obs0, exp); end
    end
    #2 rst_n = 1'b0;
    #1;
    exp = '0;
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL async_clear got %b exp %b", obs0, exp); end
    @(negedge clk); #1;
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL async_held got %b exp %b", obs0, exp); end
    req = 4'b1111;
    rst_n = 1'b1;
    @(negedge clk); #1;
    exp = {4'b0001, 4'b0001, 2'b00, 1'b1, 2'b00};
    vectors++;
    if (obs0 !== exp) begin miscompares++; $display("FAIL async_ptr_reset got %b exp %b", obs0, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_rr_burst1();
    test_stall();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
